texture_scan_loader: RTL and testbench

TEXTURE_SCAN_LOADER -- requirements
Module: texture_scan_loader

---
 rtl/texture_scan_loader.sv | 149 ++++++++++++++
 tb/tb_texture_scan_loader.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/texture_scan_loader.sv
// rtl/texture_scan_loader.sv - scan-pad frame deserializer that issues texture byte writes
//
// Purpose: captures 20-bit frames from a two-phase scan interface
// (phi1 master / phi2 slave clocks, latch commit, serial data). The
// interface is asynchronous to clk. Each valid frame becomes one
// texture write. The block raises load_done after TEX_WORDS writes
// have been accepted.
//
// Ports:
//   clk, rst_n          system clock, async active-low reset
//   scan_phi1/phi2      scan master/slave clock pads (async)
//   scan_latch          frame commit pad (async)
//   scan_data           serial data pad (async)
//   tex_wr_valid/ready  texture write handshake
//   tex_wr_addr/data    texture byte address / byte
//   load_done           sticky, TEX_WORDS writes accepted
//   err_flags           sticky {phase, overrun, frame}
module texture_scan_loader #(
  parameter int SYNC_STAGES = 2,
  parameter int TEX_WORDS   = 2048
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        scan_phi1,
  input  logic        scan_phi2,
  input  logic        scan_latch,
  input  logic        scan_data,
  output logic        tex_wr_valid,
  input  logic        tex_wr_ready,
  output logic [10:0] tex_wr_addr,
  output logic [7:0]  tex_wr_data,
  output logic        load_done,
  output logic [2:0]  err_flags
);

  typedef enum logic [1:0] {ST_SHIFT, ST_WRITE, ST_DONE} state_e;

  localparam logic [11:0] LAST_IDX = 12'(TEX_WORDS - 1);

  // Pad synchronizers, bit order {data, latch, phi2, phi1}
  logic [3:0] sync_q [SYNC_STAGES];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
    end else begin
      sync_q[0] <= {scan_data, scan_latch, scan_phi2, scan_phi1};
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  logic phi1_s, phi2_s, latch_s, data_s;
  assign phi1_s  = sync_q[SYNC_STAGES-1][0];
  assign phi2_s  = sync_q[SYNC_STAGES-1][1];
  assign latch_s = sync_q[SYNC_STAGES-1][2];
  assign data_s  = sync_q[SYNC_STAGES-1][3];

  state_e      state_q;
  logic [2:0]  prev_q;      // {latch, phi2, phi1} from the previous cycle
  logic        master_q;
  logic [19:0] shreg_q;
  logic [4:0]  bit_cnt_q;
  logic [11:0] acc_cnt_q;
  logic        valid_q;
  logic [10:0] addr_q;
  logic [7:0]  data_q;
  logic        done_q;
  logic [2:0]  err_q;

  logic phase_clash_d, phi1_rise_d, phi2_rise_d, latch_rise_d, frame_ok_d;

  // Overlapping phi1/phi2 is a host timing fault; any edge seen in that
  // cycle is untrustworthy, so both are suppressed.
  assign phase_clash_d = phi1_s & phi2_s;
  assign phi1_rise_d   = phi1_s & ~prev_q[0] & ~phase_clash_d;
  assign phi2_rise_d   = phi2_s & ~prev_q[1] & ~phase_clash_d;
  assign latch_rise_d  = latch_s & ~prev_q[2];
  // Guard bit was shifted first, so it sits at the top after 20 shifts
  assign frame_ok_d    = (bit_cnt_q == 5'd20) && !shreg_q[19];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_SHIFT;
      prev_q    <= '0;
      master_q  <= 1'b0;
      shreg_q   <= '0;
      bit_cnt_q <= '0;
      acc_cnt_q <= '0;
      valid_q   <= 1'b0;
      addr_q    <= '0;
      data_q    <= '0;
      done_q    <= 1'b0;
      err_q     <= '0;
    end else begin
      prev_q <= {latch_s, phi2_s, phi1_s};

      // Shifting runs in SHIFT and WRITE so the next frame can stream in
      if (state_q != ST_DONE) begin
        if (phase_clash_d) err_q[2] <= 1'b1;
        if (phi1_rise_d) master_q <= data_s;
        if (phi2_rise_d) shreg_q <= {shreg_q[18:0], master_q};
        if (latch_rise_d)
          bit_cnt_q <= '0;
        else if (phi2_rise_d && bit_cnt_q != 5'd31)
          bit_cnt_q <= bit_cnt_q + 5'd1;
      end

      case (state_q)
        ST_SHIFT: begin
          if (latch_rise_d) begin
            if (frame_ok_d) begin
              addr_q  <= shreg_q[18:8];
              data_q  <= shreg_q[7:0];
              state_q <= ST_WRITE;
            end else begin
              err_q[0] <= 1'b1;
            end
          end
        end
        ST_WRITE: begin
          // Valid rises one cycle after the frame is committed
          if (!valid_q) begin
            valid_q <= 1'b1;
          end else if (tex_wr_ready) begin
            valid_q   <= 1'b0;
            acc_cnt_q <= acc_cnt_q + 12'd1;
            if (acc_cnt_q == LAST_IDX) begin
              state_q <= ST_DONE;
              done_q  <= 1'b1;
            end else begin
              state_q <= ST_SHIFT;
            end
          end
          // A commit while a write is still pending is dropped
          if (latch_rise_d) err_q[1] <= 1'b1;
        end
        default: begin
        end
      endcase
    end
  end

  assign tex_wr_valid = valid_q;
  assign tex_wr_addr  = addr_q;
  assign tex_wr_data  = data_q;
  assign load_done    = done_q;
  assign err_flags    = err_q;

endmodule

// File: tb/tb_texture_scan_loader.sv
// tb/tb_texture_scan_loader.sv - scoreboard bench for texture_scan_loader
module tb_texture_scan_loader;

  localparam int SYNC = 2;
  localparam int TW   = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        scan_phi1 = 1'b0, scan_phi2 = 1'b0, scan_latch = 1'b0, scan_data = 1'b0;
  logic        tex_wr_valid;
  logic        tex_wr_ready = 1'b0;
  logic [10:0] tex_wr_addr;
  logic [7:0]  tex_wr_data;
  logic        load_done;
  logic [2:0]  err_flags;

  texture_scan_loader #(.SYNC_STAGES(SYNC), .TEX_WORDS(TW)) dut (
    .clk(clk), .rst_n(rst_n),
    .scan_phi1(scan_phi1), .scan_phi2(scan_phi2),
    .scan_latch(scan_latch), .scan_data(scan_data),
    .tex_wr_valid(tex_wr_valid), .tex_wr_ready(tex_wr_ready),
    .tex_wr_addr(tex_wr_addr), .tex_wr_data(tex_wr_data),
    .load_done(load_done), .err_flags(err_flags)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  int acc_count = 0;
  logic [18:0] sb_q [$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: a write is accepted on the next rising edge when valid&&ready at negedge
  always @(negedge clk) begin
    if (rst_n && tex_wr_valid && tex_wr_ready) begin
      acc_count++;
      if (sb_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_write: got addr %0h data %0h expected none", tex_wr_addr, tex_wr_data);
      end else begin
        check("write", {13'd0, tex_wr_addr, tex_wr_data}, {13'd0, sb_q.pop_front()});
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b);
    scan_data = b;
    tick(1);
    scan_phi1 = 1'b1;
    tick(4);
    scan_phi1 = 1'b0;
    scan_phi2 = 1'b1;
    tick(4);
    scan_phi2 = 1'b0;
    tick(4);
  endtask

  task automatic send_frame(input logic guard, input logic [10:0] addr,
                            input logic [7:0] data, input int nbits);
    logic [19:0] f;
    f = {guard, addr, data};
    for (int i = 0; i < nbits; i++) send_bit(f[19-i]);
  endtask

  task automatic pulse_latch();
    scan_latch = 1'b1;
    tick(4);
    scan_latch = 1'b0;
    tick(4);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick(2);
    rst_n = 1'b1;
    tick(2);
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while (sb_q.size() != 0 && n < 200) begin
      tick(1);
      n++;
    end
    check(name, sb_q.size(), 0);
  endtask

  initial begin
    int lat;
    int acc0;
    logic stable;
    tick(2);
    check("reset_outputs", {tex_wr_valid, tex_wr_addr, tex_wr_data, load_done, err_flags}, 0);
    rst_n = 1'b1;
    tick(2);

    // Basic frame with latency measurement
    tex_wr_ready = 1'b1;
    send_frame(1'b0, 11'h005, 8'hA7, 20);
    sb_q.push_back({11'h005, 8'hA7});
    scan_latch = 1'b1;
    lat = 0;
    while (!tex_wr_valid && lat < 20) begin
      tick(1);
      lat++;
    end
    check("latch_to_valid_latency", lat, SYNC + 2);
    tick(4);
    scan_latch = 1'b0;
    tick(4);
    drain("basic_drain");
    check("basic_err", err_flags, 3'b000);
    check("basic_valid_low", tex_wr_valid, 1'b0);

    // Stall for 10 cycles
    tex_wr_ready = 1'b0;
    acc0 = acc_count;
    send_frame(1'b0, 11'h3C2, 8'h5E, 20);
    sb_q.push_back({11'h3C2, 8'h5E});
    pulse_latch();
    stable = 1'b1;
    for (int i = 0; i < 10; i++) begin
      if (!(tex_wr_valid && tex_wr_addr == 11'h3C2 && tex_wr_data == 8'h5E)) stable = 1'b0;
      tick(1);
    end
    check("stall_hold", stable, 1'b1);
    tex_wr_ready = 1'b1;
    tick(2);
    tex_wr_ready = 1'b0;
    check("stall_one_accept", acc_count - acc0, 1);
    drain("stall_drain");
    check("hold_after_write", {tex_wr_valid, tex_wr_addr, tex_wr_data}, {1'b0, 11'h3C2, 8'h5E});

    // Short frame (19 bits)
    do_reset();
    tex_wr_ready = 1'b1;
    acc0 = acc_count;
    send_frame(1'b0, 11'h123, 8'h45, 19);
    pulse_latch();
    tick(4);
    check("short_frame_err", err_flags, 3'b001);
    check("short_frame_nowrite", acc_count - acc0, 0);

    // Guard bit set
    do_reset();
    send_frame(1'b1, 11'h0AA, 8'h55, 20);
    pulse_latch();
    tick(4);
    check("guard_err", err_flags, 3'b001);
    check("guard_nowrite", acc_count - acc0, 0);

    // Overrun: second frame latched during a stalled write
    do_reset();
    tex_wr_ready = 1'b0;
    acc0 = acc_count;
    send_frame(1'b0, 11'h011, 8'h22, 20);
    sb_q.push_back({11'h011, 8'h22});
    pulse_latch();
    send_frame(1'b0, 11'h033, 8'h44, 20);
    pulse_latch();
    check("overrun_err", err_flags, 3'b010);
    check("overrun_pending", {tex_wr_valid, tex_wr_addr, tex_wr_data}, {1'b1, 11'h011, 8'h22});
    tex_wr_ready = 1'b1;
    drain("overrun_drain");
    tick(10);
    check("overrun_one_write", acc_count - acc0, 1);

    // Phase overlap
    do_reset();
    scan_phi1 = 1'b1;
    scan_phi2 = 1'b1;
    tick(4);
    scan_phi1 = 1'b0;
    scan_phi2 = 1'b0;
    tick(4);
    check("phase_err", err_flags, 3'b100);

    // Reset mid-write
    tex_wr_ready = 1'b0;
    send_frame(1'b0, 11'h7FF, 8'hFF, 20);
    pulse_latch();
    rst_n = 1'b0;
    #1;
    check("reset_mid_write", {tex_wr_valid, tex_wr_addr, tex_wr_data, load_done, err_flags}, 0);
    tick(2);
    rst_n = 1'b1;
    tick(2);

    // Reset mid-frame, then clean frame
    tex_wr_ready = 1'b1;
    send_frame(1'b0, 11'h555, 8'h99, 10);
    rst_n = 1'b0;
    #1;
    check("reset_mid_frame", {tex_wr_valid, tex_wr_addr, tex_wr_data, load_done, err_flags}, 0);
    scan_data = 1'b0;
    tick(2);
    rst_n = 1'b1;
    tick(2);
    send_frame(1'b0, 11'h246, 8'h81, 20);
    sb_q.push_back({11'h246, 8'h81});
    pulse_latch();
    drain("post_reset_drain");
    check("post_reset_err", err_flags, 3'b000);

    // Full load of TW frames, then one extra
    do_reset();
    tex_wr_ready = 1'b1;
    for (int a = 0; a < TW; a++) begin
      logic [10:0] ad;
      ad = 11'(a);
      send_frame(1'b0, ad, ad[7:0], 20);
      sb_q.push_back({ad, ad[7:0]});
      pulse_latch();
      if (a == TW - 2) begin
        drain("load_penultimate_drain");
        check("done_before_last", load_done, 1'b0);
      end
    end
    drain("load_drain");
    check("load_done", load_done, 1'b1);
    acc0 = acc_count;
    send_frame(1'b0, 11'h100, 8'h01, 20);
    pulse_latch();
    tick(10);
    check("done_ignores_frame", acc_count - acc0, 0);
    check("done_state", {tex_wr_valid, load_done, err_flags}, {1'b0, 1'b1, 3'b000});
    check("done_hold_last", {tex_wr_addr, tex_wr_data}, {11'(TW - 1), 8'(TW - 1)});

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
